// File: rtl/seg7_display.sv
// Memory-mapped 8-digit hex display driver: the CPU writes a 32-bit value in two
// halfwords, and the block scans it onto a common-anode 7-segment display.
module seg7_display #(
  parameter int REFRESH_DIV = 50000,
  parameter bit LZ_BLANK    = 1'b0
) (
  input  logic        segclk,
  input  logic        segrst,
  input  logic        segcs,
  input  logic [1:0]  segaddr,
  input  logic        segwrite,
  input  logic [15:0] segwdata,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [31:0]      data_r;
  logic [DIV_W-1:0] div_r;
  logic [2:0]       idx_r;
  logic [7:0]       seg_en_r;
  logic [7:0]       seg_out_r;

  logic [31:0]      data_nxt_s;
  logic [DIV_W-1:0] div_nxt_s;
  logic [2:0]       idx_nxt_s;
  logic [3:0]       nibble_s;
  logic             blank_s;
  logic [7:0]       seg_en_nxt_s;
  logic [7:0]       seg_out_nxt_s;

  // Hex digit to active-low {dp,g,f,e,d,c,b,a}; dp is never lit.
  function automatic logic [7:0] hex_decode(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0:    pat = 8'hC0;
      4'h1:    pat = 8'hF9;
      4'h2:    pat = 8'hA4;
      4'h3:    pat = 8'hB0;
      4'h4:    pat = 8'h99;
      4'h5:    pat = 8'h92;
      4'h6:    pat = 8'h82;
      4'h7:    pat = 8'hF8;
      4'h8:    pat = 8'h80;
      4'h9:    pat = 8'h90;
      4'hA:    pat = 8'h88;
      4'hB:    pat = 8'h83;
      4'hC:    pat = 8'hC6;
      4'hD:    pat = 8'hA1;
      4'hE:    pat = 8'h86;
      4'hF:    pat = 8'h8E;
      default: pat = 8'hFF;
    endcase
    return pat;
  endfunction

  // True when nibble pos and every nibble above it are zero.
  function automatic logic upper_zero(input logic [31:0] d, input logic [2:0] pos);
    logic z;
    z = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if ((k >= int'(pos)) && (d[4*k +: 4] != 4'h0)) begin
        z = 1'b0;
      end else begin
        z = z;
      end
    end
    return z;
  endfunction

  // Halfword write decode; unmapped addresses and idle strobes leave data alone.
  always_comb begin
    data_nxt_s = data_r;
    if (segcs && segwrite) begin
      case (segaddr)
        2'b00:   data_nxt_s[15:0]  = segwdata;
        2'b10:   data_nxt_s[31:16] = segwdata;
        default: data_nxt_s        = data_r;
      endcase
    end else begin
      data_nxt_s = data_r;
    end
  end

  // Refresh divider; the scan index steps on the divider's last count.
  always_comb begin
    div_nxt_s = div_r;
    idx_nxt_s = idx_r;
    if (div_r == DIV_LAST) begin
      div_nxt_s = {DIV_W{1'b0}};
      idx_nxt_s = idx_r + 3'd1;
    end else begin
      div_nxt_s = div_r + DIV_W'(1);
      idx_nxt_s = idx_r;
    end
  end

  // Pattern for the digit currently addressed, from pre-edge index and data.
  always_comb begin
    nibble_s      = data_r[{idx_r, 2'b00} +: 4];
    blank_s       = 1'b0;
    seg_en_nxt_s  = ~(8'b0000_0001 << idx_r);
    seg_out_nxt_s = 8'hFF;
    if (LZ_BLANK && (idx_r != 3'd0)) begin
      blank_s = upper_zero(data_r, idx_r);
    end else begin
      blank_s = 1'b0;
    end
    if (blank_s) begin
      seg_out_nxt_s = 8'hFF;
    end else begin
      seg_out_nxt_s = hex_decode(nibble_s);
    end
  end

  // All state moves on the falling edge, in step with CPU IO access.
  always_ff @(negedge segclk) begin
    if (segrst) begin
      data_r    <= 32'h0000_0000;
      div_r     <= {DIV_W{1'b0}};
      idx_r     <= 3'd0;
      seg_en_r  <= 8'hFE;
      seg_out_r <= 8'hC0;
    end else begin
      data_r    <= data_nxt_s;
      div_r     <= div_nxt_s;
      idx_r     <= idx_nxt_s;
      seg_en_r  <= seg_en_nxt_s;
      seg_out_r <= seg_out_nxt_s;
    end
  end

  assign seg_en  = seg_en_r;
  assign seg_out = seg_out_r;

endmodule

// File: doc/seg7_display.md
Name: seg7_display

Overview:
- Memory-mapped output peripheral: the CPU-to-board counterpart of the switch input port.
- The CPU writes a 32-bit value in two 16-bit halves through the MemOrIO chip-select/address path.
- The block time-multiplexes the value as 8 hex digits onto the board's common-anode 7-segment display.
- Driven by the CPU clock, with a built-in refresh divider.

Parameters:
- REFRESH_DIV, 50000, segclk cycles each digit stays lit before the scan advances (≥2; benches use 4).
- LZ_BLANK, 0, 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all 8 digits.

Ports:
- segclk  input  1  clock; all state changes on the falling edge (same edge as CPU IO access)
- segrst  input  1  synchronous active-high reset
- segcs  input  1  chip select from MemOrIO
- segaddr  input  2  halfword address within the block: 2'b00 = low half, 2'b10 = high half
- segwrite  input  1  write strobe from CPU
- segwdata  input  16  write data from CPU
- seg_en  output  8  digit enables, active-low, bit i = digit i (digit 0 rightmost)
- seg_out  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}

Behaviour:
- Clocking: one clock, segclk; all registers update on its falling edge.
- Reset: synchronous, active-high; takes priority over everything, including mid-scan and mid-write.
- Reset values:
  - data register = 32'h0, divider = 0, digit index = 0.
  - seg_en = 8'hFE, seg_out = 8'hC0 (digit 0 showing "0").
- Write port:
  - Accepted when segcs && segwrite.
  - segaddr 2'b00 loads data[15:0] <= segwdata; 2'b10 loads data[31:16] <= segwdata; the other half is unchanged.
  - segaddr 2'b01/2'b11, or segcs/segwrite low: no change.
  - No read-back.
- Divider:
  - Counts 0..REFRESH_DIV-1 every cycle, then wraps to 0.
  - Digit index advances only on the cycle the divider is at REFRESH_DIV-1.
  - Digit index is 3 bits and wraps 7 -> 0.
- Outputs are registered. Each edge:
  - seg_en <= ~(1 << idx) and seg_out <= decode(data[4*idx+3:4*idx]), using the pre-edge idx and data values.
  - Write latency: write at edge k updates data at k; the current digit's pattern reflects it at edge k+1.
  - Digit latency: a new index is driven one edge after it is entered.
  - Exactly one seg_en bit is low at all times after reset.
- Decode (hex to active-low segments):
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E
  - dp is always off (bit 7 = 1).
- Leading-zero blanking (LZ_BLANK=1):
  - Digit i≥1 shows seg_out = 8'hFF when nibbles i..7 are all zero; its seg_en bit is still driven low.
  - Evaluated on the current data each edge.
- Simultaneous events: a write and a scan advance on the same edge both take effect. The output for that edge uses the old data and the old index.
- No internal handshake; every write completes in one cycle.

Test Plan:
- Reset check (REFRESH_DIV=4): assert segrst 2 cycles -> seg_en=FE, seg_out=C0; release -> idx advances every 4 cycles; one full scan = 32 cycles with seg_en walking FE,FD,FB,...,7F,FE.
- Low-half write: addr 00, segwdata 16'h1234, cs=1, wr=1 -> digits 0..3 show 4,3,2,1 (99,B0,A4,F9); digits 4..7 show C0.
- High-half write then low-half write: addr 10 16'hABCD, then addr 00 16'hEF09 -> digits 0..7 = 9,0,F,E,D,C,b,A (90,C0,8E,86,A1,C6,83,88); the low write leaves the high half intact.
- Ignored writes: addr 01/11 data FFFF, or cs=0 with wr=1, or wr=0 with cs=1 -> data unchanged (still ABCDEF09).
- Leading-zero blanking (LZ_BLANK=1): data 32'h0000_00A0 -> digits 0,1 = C0,88; digits 2..7 = FF; data 0 -> digit 0 = C0, others FF.
- Mid-scan reset and edge collision:
  - segrst at idx=5, divider=2 -> next edge idx=0, data=0, outputs FE/C0.
  - A write landing on the advance edge -> new data appears on the following edge's digit.
